// File: rtl/snr_pkg.sv
// rtl/snr_pkg.sv - shared widths, dB scale constant and FSM states for the SNR dB converter
package snr_pkg;

  // Default datapath widths
  localparam int DEF_IN_WIDTH   = 32;
  localparam int DEF_FRAC_BITS  = 8;
  localparam int DEF_MANT_WIDTH = 16;
  localparam int DEF_OUT_WIDTH  = 16;

  // 10*log10(2) in Q2.14, and the shift that removes its fraction
  localparam int LOG10_2_X10_Q14 = 49321;
  localparam int LOG10_2_SHIFT   = 14;
  localparam int LOG10_2_WIDTH   = 16;

  // Conversion sequence
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NORM  = 3'd1,
    ST_FRAC  = 3'd2,
    ST_SCALE = 3'd3,
    ST_DONE  = 3'd4
  } snr_state_e;

endpackage

// File: rtl/snr_db_convert_msb_detect.sv
// rtl/snr_db_convert_msb_detect.sv - leading-one priority encoder with all-zero flag
module msb_detect
  import snr_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  localparam int IDX_W   = $clog2(IN_WIDTH)
) (
  input  logic [IN_WIDTH-1:0] x,
  output logic [IDX_W-1:0]    msb,
  output logic                zero
);

  // Scan upward so the highest set bit wins; msb is 0 when x is 0
  always_comb begin
    msb  = '0;
    zero = 1'b1;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (x[i]) begin
        msb  = IDX_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/snr_db_convert.sv
// rtl/snr_db_convert.sv - iterative linear-ratio to signed fixed-point dB converter
module snr_db_convert
  import snr_pkg::*;
#(
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int MANT_WIDTH = DEF_MANT_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_db,
  input  logic [IN_WIDTH-1:0]         snr_linear,
  output logic signed [OUT_WIDTH-1:0] snr_db,
  output logic                        zero_in,
  output logic                        done_db
);

  localparam int IDX_W  = $clog2(IN_WIDTH);
  localparam int CNT_W  = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;
  localparam int SQ_W   = 2 * MANT_WIDTH;
  localparam int L_W    = IDX_W + FRAC_BITS;
  localparam int PROD_W = L_W + LOG10_2_WIDTH + 1;

  localparam logic [CNT_W-1:0]     CNT_LOAD   = CNT_W'(FRAC_BITS - 1);
  localparam logic [PROD_W-1:0]    COEF       = PROD_W'(LOG10_2_X10_Q14);
  localparam logic [PROD_W-1:0]    ROUND_HALF = PROD_W'(1) << (LOG10_2_SHIFT - 1);
  localparam logic [OUT_WIDTH-1:0] DB_MIN     = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  snr_state_e            state;
  logic [IN_WIDTH-1:0]   x_q;
  logic [IDX_W-1:0]      msb_q;
  logic [MANT_WIDTH-1:0] m_q;
  logic [FRAC_BITS-1:0]  frac_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  zero_q;

  logic [IDX_W-1:0]      msb_c;
  logic                  zero_c;
  logic [IDX_W-1:0]      shamt;
  logic [IN_WIDTH-1:0]   x_norm;
  logic [MANT_WIDTH-1:0] mant_c;
  logic [SQ_W-1:0]       sq;
  logic                  frac_bit;
  logic [MANT_WIDTH-1:0] m_next;
  logic [L_W-1:0]        l_val;
  logic [PROD_W-1:0]     prod;
  logic [OUT_WIDTH-1:0]  db_c;

  msb_detect #(.IN_WIDTH(IN_WIDTH)) u_msb_detect (
    .x    (x_q),
    .msb  (msb_c),
    .zero (zero_c)
  );

  // Normalise x so its leading one lands in the top bit; mantissa is Q1.(M-1) in [1,2)
  assign shamt  = IDX_W'(IN_WIDTH - 1) - msb_c;
  assign x_norm = x_q << shamt;
  assign mant_c = MANT_WIDTH'(x_norm >> (IN_WIDTH - MANT_WIDTH));

  // Squaring step: if m*m reaches 2 the fraction bit is 1 and the square is halved
  assign sq       = SQ_W'(m_q) * SQ_W'(m_q);
  assign frac_bit = sq[SQ_W-1];
  assign m_next   = frac_bit ? MANT_WIDTH'(sq >> MANT_WIDTH)
                             : MANT_WIDTH'(sq >> (MANT_WIDTH - 1));

  // log2 to dB: multiply by 10*log10(2), round half up, drop the constant's fraction
  assign l_val = {msb_q, frac_q};
  assign prod  = PROD_W'(l_val) * COEF + ROUND_HALF;
  assign db_c  = OUT_WIDTH'(prod >> LOG10_2_SHIFT);

  // Conversion FSM: capture, normalise, extract fraction bits, scale, then hold until start falls
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      x_q     <= '0;
      msb_q   <= '0;
      m_q     <= '0;
      frac_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      snr_db  <= '0;
      zero_in <= 1'b0;
      done_db <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_db) begin
            x_q   <= snr_linear;
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          msb_q  <= msb_c;
          m_q    <= mant_c;
          frac_q <= '0;
          cnt_q  <= CNT_LOAD;
          zero_q <= zero_c;
          state  <= zero_c ? ST_SCALE : ST_FRAC;
        end
        ST_FRAC: begin
          m_q    <= m_next;
          frac_q <= {frac_q[FRAC_BITS-2:0], frac_bit};
          if (cnt_q == '0) begin
            state <= ST_SCALE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SCALE: begin
          snr_db  <= zero_q ? DB_MIN : db_c;
          zero_in <= zero_q;
          done_db <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          if (!start_db) begin
            done_db <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/snr_db_convert.md
# snr_db_convert

Converts the unsigned linear SNR ratio produced by the SNR stage into signed fixed-point decibels (10·log10). It sits directly downstream of the linear SNR calculator: it consumes `snr_linear` when that stage's done flag is high, and drives the dB value to the heart-rate quality logic. The computation is iterative: leading-one detection, then bit-serial log2 fraction extraction, then one constant multiply.

## Interface
- `IN_WIDTH`, 32: width of `snr_linear`.
- `FRAC_BITS`, 8: fractional bits of log2 and of `snr_db`; also the number of FRAC iterations.
- `MANT_WIDTH`, 16: normalized mantissa precision, Q1.(MANT_WIDTH-1).
- `OUT_WIDTH`, 16: `snr_db` width, signed Q(OUT_WIDTH-FRAC_BITS).FRAC_BITS.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start_db`  in  1: level request, normally tied to upstream done. Sampled only in IDLE.
- `snr_linear`  in  IN_WIDTH: unsigned ratio. Captured on the edge leaving IDLE.
- `snr_db`  out  OUT_WIDTH: signed dB result. Holds until the next completion.
- `zero_in`  out  1: last captured input was 0. Valid with `done_db`.
- `done_db`  out  1: result valid.

## Operation
- Reset values: `snr_db`=0, `zero_in`=0, `done_db`=0, state IDLE.
- States and transitions:
  - IDLE: if `start_db`=1, capture `snr_linear` into x, go to NORM.
  - NORM: msb = index of the leading one of x. Integer part of log2 = msb. Mantissa m = top MANT_WIDTH bits of (x << (IN_WIDTH-1-msb)). Go to FRAC. If x=0, go directly to SCALE with the zero flag set.
  - FRAC: runs FRAC_BITS cycles, MSB-first. Each cycle, p = m·m (Q2.(2M-2)).
    - If p[2M-1]=1: the fraction bit is 1 and m = p[2M-1:M].
    - Otherwise: the fraction bit is 0 and m = p[2M-2:M-1].
    - Truncate in both cases. After the last bit, go to SCALE.
  - SCALE: L = {msb, frac}, unsigned Q5.FRAC_BITS. `snr_db` = round_half_up((L · 49321) >> 14), where 49321 = 10·log10(2) in Q2.14.
    - No saturation is needed for the default parameters (max ≈96.3 dB).
    - If the zero flag is set: `snr_db` = most negative value (0x8000) and `zero_in`=1. Otherwise `zero_in`=0.
    - Set `done_db`=1 and go to DONE.
  - DONE: `done_db` stays 1 while `start_db`=1. When `start_db`=0, clear `done_db` and go to IDLE on that edge.
- Because of the DONE rule, a `start_db` held high produces exactly one conversion. A new conversion requires `start_db` to fall and rise again.
- Dropping `start_db` during NORM/FRAC/SCALE does not abort the conversion. `done_db` is then high for exactly one cycle.
- Changes on `snr_linear` after capture are ignored.
- Reset in any state returns to IDLE on that edge and clears all outputs.

## Timing
- Latency: `done_db` and `snr_db` update on edge FRAC_BITS+3 after the first edge sampling `start_db`=1 in IDLE. This is 11 edges for the default parameters.
- Zero input: the conversion skips FRAC, so the result appears on edge 3.
- One conversion in flight at a time. There is no back-pressure beyond the `start_db` level.
- `snr_db` and `zero_in` change only on the SCALE→DONE edge or on reset.

## Structure
- Shared package `snr_pkg` holds:
  - the state enum (IDLE, NORM, FRAC, SCALE, DONE);
  - `LOG10_2_X10_Q14` = 49321 and its shift of 14;
  - the default widths.
- Sub-module `msb_detect`: combinational priority encoder, IN_WIDTH → $clog2(IN_WIDTH), plus a zero flag. The shifter, squarer, bit counter and FSM stay in the top module.

## Test plan
- `snr_linear`=1, `start_db` pulse → at edge 11: `done_db`=1, `snr_db`=0x0000, `zero_in`=0.
- `snr_linear`=2 → `snr_db`=0x0303 (3.012 dB).
- `snr_linear`=100 → `snr_db`=0x13FE ±1 LSB (ideal 20.0 dB = 0x1400).
- `snr_linear`=0xFFFFFFFF → `snr_db`=0x6051 ±1 LSB.
- `snr_linear`=0 → at edge 3: `snr_db`=0x8000, `zero_in`=1, `done_db`=1.
- Handshake and reset:
  - Hold `start_db` high for 30 cycles → exactly one conversion, `done_db` stays high until `start_db` falls, then 0 the next edge.
  - Toggle `snr_linear` mid-FRAC → result unchanged.
  - Assert `reset` during FRAC → next edge shows IDLE and all outputs 0.
  - A subsequent start → correct result at edge 11.
